// File: rtl/uart_rx_sequencer_pkg.sv
// Shared register map, bit positions and FSM encoding for the UART receive sequencer.
package uart_rx_sequencer_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    localparam int unsigned CTRL_WMODE   = 0;
    localparam int unsigned CTRL_IE      = 1;
    localparam int unsigned CTRL_ERR_CLR = 2;
    localparam int unsigned CTRL_FLUSH   = 3;

    localparam int unsigned STAT_VALID   = 0;
    localparam int unsigned STAT_ERR     = 1;
    localparam int unsigned STAT_CNT_LSB = 2;
    localparam int unsigned STAT_WMODE   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CAPT   = 3'd3,
        ST_SETTLE = 3'd4
    } state_e;

    function automatic logic [31:0] pack_stat(input logic wmode, input logic [2:0] cnt,
                                              input logic err, input logic valid);
        return {23'b0, wmode, 3'b0, cnt, err, valid};
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Saturating idle counter; fire_c pulses on the enabled cycle whose increment reaches TIMEOUT.
module uart_rx_timeout #(
    parameter int unsigned TIMEOUT = 115200,
    parameter int unsigned TO_W    = 17
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic fire_c
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count_q <= '0;
        end else if (en && (count_q != LIMIT)) begin
            count_q <= count_q + TO_W'(1);
        end
    end

    // TIMEOUT of zero disables the flush entirely
    assign fire_c = (TIMEOUT != 0) && en && (count_q == LIMIT - TO_W'(1));

endmodule

// File: rtl/uart_rx_sequencer.sv
// Pops the UART receive FIFO and exposes it to the core as DATA/STAT/CTRL MMIO registers,
// in byte mode or little-endian 32-bit word mode with a timeout flush of partial words.
module uart_rx_sequencer
    import uart_rx_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_RD_LAT = 1,
    parameter int unsigned TIMEOUT     = 115200,
    parameter int unsigned TO_W        = 17
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_STATUS,
    input  logic [7:0]  RX_DATA,
    output logic [7:0]  RX_CONTROL,
    input  logic [1:0]  ADDR,
    input  logic        RE,
    input  logic        WE,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        IRQ
);

    localparam int unsigned     LAT_W    = (FIFO_RD_LAT > 1) ? $clog2(FIFO_RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(FIFO_RD_LAT - 1);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [31:0]      hold_q, hold_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             wmode_q, wmode_d;
    logic             ie_q, ie_d;
    logic             rreq_q, irq_q;

    logic ctrl_wr, flush, data_rd_ok, tmr_en, tmr_clr, tmr_fire;
    logic unused_wdata;

    // A read strobe always wins over a simultaneous write
    assign ctrl_wr    = WE && !RE && (ADDR == ADDR_CTRL);
    assign flush      = ctrl_wr && (WDATA[CTRL_FLUSH] ||
                        ((WDATA[CTRL_WMODE] != wmode_q) && (cnt_q != 3'd0)));
    assign data_rd_ok = RE && (ADDR == ADDR_DATA) && valid_q;
    assign tmr_en     = (state_q == ST_IDLE) && wmode_q && (cnt_q != 3'd0) &&
                        (cnt_q < 3'd4) && !valid_q;
    assign tmr_clr    = (state_q == ST_CAPT) || flush || data_rd_ok;
    assign unused_wdata = ^WDATA[31:4];

    uart_rx_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
        .CLK    (CLK),
        .RST    (RST),
        .en     (tmr_en),
        .clr    (tmr_clr),
        .fire_c (tmr_fire)
    );

    // Pop sequencing; a timeout edge also blocks a pop since VALID rises on it
    always_comb begin
        state_d = state_q;
        lat_d   = '0;
        case (state_q)
            ST_IDLE:   if ((RX_STATUS != 8'h00) && !valid_q && !tmr_fire) state_d = ST_POP;
            ST_POP:    state_d = ST_WAIT;
            ST_WAIT: begin
                if (lat_q == LAT_LAST) state_d = ST_CAPT;
                else                   lat_d   = lat_q + LAT_W'(1);
            end
            ST_CAPT:   state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Register file, flush, packing and read side effects
    always_comb begin
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        wmode_d = wmode_q;
        ie_d    = ie_q;
        rdata_d = rdata_q;

        if (ctrl_wr) begin
            wmode_d = WDATA[CTRL_WMODE];
            ie_d    = WDATA[CTRL_IE];
            if (WDATA[CTRL_ERR_CLR]) err_d = 1'b0;
        end

        if (flush) begin
            hold_d  = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (tmr_fire) begin
            valid_d = 1'b1;
        end

        if (RE) begin
            case (ADDR)
                ADDR_DATA: begin
                    if (valid_q) begin
                        rdata_d = hold_q;
                        hold_d  = '0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
                ADDR_STAT: rdata_d = pack_stat(wmode_q, cnt_q, err_q, valid_q);
                ADDR_CTRL: rdata_d = {30'b0, ie_q, wmode_q};
                default:   rdata_d = '0;
            endcase
        end

        // Capture lands after any same-cycle flush, starting a clean word
        if (state_q == ST_CAPT) begin
            if (!wmode_d) begin
                hold_d  = {24'b0, RX_DATA};
                cnt_d   = 3'd1;
                valid_d = 1'b1;
            end else begin
                hold_d[{cnt_d[1:0], 3'b000} +: 8] = RX_DATA;
                cnt_d   = cnt_d + 3'd1;
                valid_d = (cnt_d == 3'd4);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wmode_q <= 1'b0;
            ie_q    <= 1'b0;
            rdata_q <= '0;
            rreq_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wmode_q <= wmode_d;
            ie_q    <= ie_d;
            rdata_q <= rdata_d;
            rreq_q  <= (state_d == ST_POP);
            irq_q   <= valid_d && ie_d;
        end
    end

    assign RX_CONTROL = {7'b0, rreq_q};
    assign RDATA      = rdata_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer with a behavioural receive FIFO (1-cycle read latency).
module tb_uart_rx_sequencer;

    logic        CLK;
    logic        RST;
    logic [7:0]  rx_status_r;
    logic [7:0]  rx_data_r;
    logic [7:0]  RX_CONTROL;
    logic [1:0]  ADDR;
    logic        RE;
    logic        WE;
    logic [31:0] WDATA;
    logic [31:0] RDATA;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;
    int viol   = 0;
    logic rreq_prev;

    uart_rx_sequencer #(.FIFO_RD_LAT(1), .TIMEOUT(16), .TO_W(17)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_STATUS  (rx_status_r),
        .RX_DATA    (rx_data_r),
        .RX_CONTROL (RX_CONTROL),
        .ADDR       (ADDR),
        .RE         (RE),
        .WE         (WE),
        .WDATA      (WDATA),
        .RDATA      (RDATA),
        .IRQ        (IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Receive FIFO model: pop lands in the data register, status lags one cycle
    always @(posedge CLK) begin
        if (RX_CONTROL[0]) begin
            pops <= pops + 1;
            if (rreq_prev === 1'b1) viol <= viol + 1;
            if (wr_ptr != rd_ptr) begin
                rx_data_r <= fifo_mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        rreq_prev   <= RX_CONTROL[0];
        rx_status_r <= ((wr_ptr - rd_ptr) > (RX_CONTROL[0] ? 1 : 0)) ? 8'h01 : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mmio_rd(input logic [1:0] a, output logic [31:0] d);
        ADDR = a;
        RE   = 1'b1;
        @(negedge CLK);
        RE   = 1'b0;
        d    = RDATA;
    endtask

    task automatic mmio_wr(input logic [1:0] a, input logic [31:0] d);
        ADDR  = a;
        WDATA = d;
        WE    = 1'b1;
        @(negedge CLK);
        WE    = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int base;

        RST = 1'b1; RE = 1'b0; WE = 1'b0; ADDR = 2'd0; WDATA = '0;
        tick(3);
        chk("reset_rx_control", 32'(RX_CONTROL), 32'h0);
        chk("reset_rdata", RDATA, 32'h0);
        chk("reset_irq", 32'(IRQ), 32'h0);
        RST = 1'b0;
        tick(1);
        mmio_rd(2'd1, rd); chk("reset_stat", rd, 32'h0);

        // RE and WE together: the write must be dropped
        ADDR = 2'd2; WDATA = 32'h1; RE = 1'b1; WE = 1'b1;
        tick(1);
        RE = 1'b0; WE = 1'b0;
        mmio_rd(2'd2, rd); chk("re_we_ctrl", rd, 32'h0);
        mmio_rd(2'd3, rd); chk("reserved_read", rd, 32'h0);

        // Byte mode single byte
        base = pops;
        push(8'h41);
        tick(10);
        chk("byte_pops", 32'(pops - base), 32'd1);
        mmio_rd(2'd1, rd); chk("byte_stat", rd, 32'h0000_0005);
        mmio_rd(2'd0, rd); chk("byte_data", rd, 32'h0000_0041);
        mmio_rd(2'd1, rd); chk("byte_stat_after", rd, 32'h0);

        // Interrupt follows VALID when enabled
        mmio_wr(2'd2, 32'h2);
        push(8'h5A);
        tick(10);
        chk("irq_set", 32'(IRQ), 32'h1);
        mmio_rd(2'd2, rd); chk("ctrl_readback", rd, 32'h2);
        mmio_rd(2'd0, rd); chk("irq_data", rd, 32'h0000_005A);
        chk("irq_clear", 32'(IRQ), 32'h0);

        // Word mode packing
        mmio_wr(2'd2, 32'h1);
        base = pops;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(40);
        chk("word_pops", 32'(pops - base), 32'd4);
        mmio_rd(2'd1, rd); chk("word_stat", rd, 32'h0000_0111);
        mmio_rd(2'd0, rd); chk("word_data", rd, 32'h4433_2211);
        mmio_rd(2'd1, rd); chk("word_stat_after", rd, 32'h0000_0100);

        // Timeout flush of a two-byte partial word, observed through IRQ
        mmio_wr(2'd2, 32'h3);
        base = pops;
        push(8'hAA); push(8'hBB);
        tick(26);
        chk("timeout_early", 32'(IRQ), 32'h0);
        tick(1);
        chk("timeout_fire", 32'(IRQ), 32'h1);
        chk("timeout_pops", 32'(pops - base), 32'd2);
        mmio_rd(2'd1, rd); chk("timeout_stat", rd, 32'h0000_010B - 32'h2);
        mmio_rd(2'd0, rd); chk("timeout_data", rd, 32'h0000_BBAA);

        // Explicit and implicit flush
        mmio_wr(2'd2, 32'h1);
        base = pops;
        push(8'h12); push(8'h34);
        tick(12);
        mmio_rd(2'd1, rd); chk("flush_pre_stat", rd, 32'h0000_0108);
        mmio_wr(2'd2, 32'h9);
        mmio_rd(2'd1, rd); chk("flush_stat", rd, 32'h0000_0100);
        push(8'h56);
        tick(8);
        mmio_rd(2'd1, rd); chk("flush_one_byte", rd, 32'h0000_0104);
        mmio_wr(2'd2, 32'h0);
        mmio_rd(2'd1, rd); chk("implicit_flush", rd, 32'h0);
        chk("flush_pops", 32'(pops - base), 32'd3);

        // Backpressure in byte mode
        base = pops;
        push(8'h01); push(8'h02); push(8'h03);
        tick(20);
        chk("bp_pops1", 32'(pops - base), 32'd1);
        mmio_rd(2'd0, rd); chk("bp_data1", rd, 32'h01);
        tick(10);
        chk("bp_pops2", 32'(pops - base), 32'd2);
        mmio_rd(2'd0, rd); chk("bp_data2", rd, 32'h02);
        tick(10);
        mmio_rd(2'd0, rd); chk("bp_data3", rd, 32'h03);
        tick(10);
        chk("bp_pops3", 32'(pops - base), 32'd3);

        // Underrun sets ERR, ERR_CLR clears it
        mmio_rd(2'd0, rd); chk("underrun_data", rd, 32'h0);
        mmio_rd(2'd1, rd); chk("underrun_stat", rd, 32'h2);
        mmio_wr(2'd2, 32'h4);
        mmio_rd(2'd1, rd); chk("err_clr_stat", rd, 32'h0);

        // Reset during WAIT: popped byte is lost, no pop until data reappears
        mmio_rd(2'd2, rd);
        base = pops;
        push(8'h77);
        tick(3);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("rst_mid_rx_control", 32'(RX_CONTROL), 32'h0);
        chk("rst_mid_irq", 32'(IRQ), 32'h0);
        chk("rst_mid_rdata", RDATA, 32'h0);
        tick(10);
        chk("rst_mid_pops", 32'(pops - base), 32'd1);
        mmio_rd(2'd1, rd); chk("rst_mid_stat", rd, 32'h0);
        push(8'h78);
        tick(10);
        chk("rst_after_pops", 32'(pops - base), 32'd2);
        mmio_rd(2'd0, rd); chk("rst_after_data", rd, 32'h78);

        tick(2);
        chk("rreq_single_cycle", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
